clz_arbiter: RTL and testbench

Round-robin scheduler that shares one `clz_clk` count-leading-zeros unit between `n_req` requesters in generated datapaths (e.g. normalisation stages). It accepts one operand at a time over a valid/ready handshake and sequences it through the shared unit. The result is returned tagged with the requester index. It is the only block allowed to drive a `clz_clk` instance that has more than one consumer.

---
 rtl/clz_arbiter_pkg.sv | 21 ++
 rtl/clz_arbiter_clz.sv | 62 ++++++
 rtl/clz_arbiter.sv | 156 +++++++++++++++
 tb/tb_clz_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clz_arbiter_pkg.sv
// Shared definitions for the clz_arbiter slice: FSM state encoding and a
// width helper used to size index and counter fields.
package clz_arbiter_pkg;

  typedef enum logic [1:0] {
    CLZA_IDLE  = 2'd0,
    CLZA_ISSUE = 2'd1,
    CLZA_WAIT  = 2'd2,
    CLZA_RESP  = 2'd3
  } clza_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clz_arbiter_clz.sv
// Registered count-leading-zeros unit (clz_clk): pout/vout follow b one cycle
// later; an all-zero operand saturates pout to all ones.
module clz_clk
  import clz_arbiter_pkg::*;
#(
  parameter int bits_in  = 16,
  parameter int bits_out = clog2(bits_in)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bits_in-1:0]  b,
  output logic                ready,
  output logic                vout,
  output logic [bits_out-1:0] pout
);

  logic                ready_r;
  logic                vout_r;
  logic [bits_out-1:0] pout_r;

  function automatic logic [bits_out-1:0] clz_f(input logic [bits_in-1:0] v);
    logic [bits_out-1:0] n;
    logic                found;
    n     = {bits_out{1'b0}};
    found = 1'b0;
    for (int i = bits_in - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          n = n + bits_out'(1'b1);
        end
      end else begin
        found = 1'b1;
      end
    end
    if (!found) begin
      n = {bits_out{1'b1}};
    end else begin
      n = n;
    end
    return n;
  endfunction

  // Result register: one-cycle count of the presented operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      vout_r  <= 1'b0;
      pout_r  <= {bits_out{1'b0}};
    end else begin
      ready_r <= 1'b1;
      vout_r  <= 1'b1;
      pout_r  <= clz_f(b);
    end
  end

  assign ready = ready_r;
  assign vout  = vout_r;
  assign pout  = pout_r;

endmodule

// File: rtl/clz_arbiter.sv
// Round-robin scheduler sharing one clz_clk unit between n_req requesters;
// one operation in flight, result tagged with the requester index.
module clz_arbiter
  import clz_arbiter_pkg::*;
#(
  parameter int n_req    = 4,
  parameter int bits_in  = 16,
  parameter int bits_out = 4,
  parameter int clz_lat  = 2,
  parameter int id_w     = clog2(n_req)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req_valid,
  input  logic [n_req*bits_in-1:0] req_data,
  output logic [n_req-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [id_w-1:0]          rsp_id,
  output logic [bits_out-1:0]      rsp_data,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int cnt_w = clog2(clz_lat) + 1;

  clza_state_e         state_r, state_nxt_s;
  logic [id_w-1:0]     ptr_r, ptr_nxt_s;
  logic [cnt_w-1:0]    cnt_r, cnt_nxt_s;
  logic [bits_in-1:0]  opnd_r, opnd_nxt_s;
  logic [id_w-1:0]     rsp_id_r, rsp_id_nxt_s;
  logic [bits_out-1:0] rsp_data_r, rsp_data_nxt_s;
  logic                rsp_valid_r;
  logic                busy_r;

  logic                grant_any_s;
  logic [id_w-1:0]     grant_id_s;
  logic                clz_ready_s;
  logic                clz_vout_s;
  logic [bits_out-1:0] clz_pout_s;

  clz_clk #(
    .bits_in  (bits_in),
    .bits_out (bits_out)
  ) u_clz (
    .clk   (clk),
    .rst   (~rst),
    .b     (opnd_r),
    .ready (clz_ready_s),
    .vout  (clz_vout_s),
    .pout  (clz_pout_s)
  );

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = ptr_r;
    for (int k = 0; k < n_req; k++) begin
      if (!grant_any_s && req_valid[ptr_r + id_w'(k)]) begin
        grant_any_s = 1'b1;
        grant_id_s  = ptr_r + id_w'(k);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // One-hot grant, only offered while idle.
  always_comb begin
    req_ready = {n_req{1'b0}};
    if ((state_r == CLZA_IDLE) && grant_any_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = {n_req{1'b0}};
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    cnt_nxt_s      = cnt_r;
    opnd_nxt_s     = opnd_r;
    rsp_id_nxt_s   = rsp_id_r;
    rsp_data_nxt_s = rsp_data_r;
    case (state_r)
      CLZA_IDLE: begin
        if (grant_any_s) begin
          opnd_nxt_s   = req_data[int'(grant_id_s)*bits_in +: bits_in];
          rsp_id_nxt_s = grant_id_s;
          state_nxt_s  = CLZA_ISSUE;
        end else begin
          state_nxt_s  = CLZA_IDLE;
        end
      end
      CLZA_ISSUE: begin
        if (clz_ready_s) begin
          cnt_nxt_s   = cnt_w'(clz_lat - 1);
          state_nxt_s = CLZA_WAIT;
        end else begin
          state_nxt_s = CLZA_ISSUE;
        end
      end
      CLZA_WAIT: begin
        if (cnt_r != {cnt_w{1'b0}}) begin
          cnt_nxt_s = cnt_r - cnt_w'(1'b1);
        end else if (clz_vout_s) begin
          rsp_data_nxt_s = clz_pout_s;
          state_nxt_s    = CLZA_RESP;
        end else begin
          state_nxt_s = CLZA_WAIT;
        end
      end
      CLZA_RESP: begin
        if (rsp_ready) begin
          ptr_nxt_s   = rsp_id_r + id_w'(1'b1);
          state_nxt_s = CLZA_IDLE;
        end else begin
          state_nxt_s = CLZA_RESP;
        end
      end
      default: begin
        state_nxt_s = CLZA_IDLE;
      end
    endcase
  end

  // State and output registers; flags are derived from the next state so
  // they line up with state_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= CLZA_IDLE;
      ptr_r       <= {id_w{1'b0}};
      cnt_r       <= {cnt_w{1'b0}};
      opnd_r      <= {bits_in{1'b0}};
      rsp_id_r    <= {id_w{1'b0}};
      rsp_data_r  <= {bits_out{1'b0}};
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      opnd_r      <= opnd_nxt_s;
      rsp_id_r    <= rsp_id_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      rsp_valid_r <= (state_nxt_s == CLZA_RESP);
      busy_r      <= (state_nxt_s != CLZA_IDLE);
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_clz_arbiter.sv
// Directed bench for clz_arbiter: hand-computed grants, ids, counts and
// latencies; inputs driven and outputs sampled on the falling edge.
module tb_clz_arbiter;

  localparam int n_req    = 4;
  localparam int bits_in  = 16;
  localparam int bits_out = 4;
  localparam int clz_lat  = 2;
  localparam int id_w     = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [n_req-1:0]         req_valid;
  logic [n_req*bits_in-1:0] req_data;
  logic [n_req-1:0]         req_ready;
  logic                     rsp_valid;
  logic [id_w-1:0]          rsp_id;
  logic [bits_out-1:0]      rsp_data;
  logic                     rsp_ready;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  int exp_id [5] = '{0, 1, 2, 3, 0};
  int exp_d  [5] = '{0, 4, 15, 0, 0};

  clz_arbiter #(
    .n_req    (n_req),
    .bits_in  (bits_in),
    .bits_out (bits_out),
    .clz_lat  (clz_lat),
    .id_w     (id_w)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts falling edges until rsp_valid is seen, bounded.
  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    check_val({tag, "_seen"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_data  = 64'd0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset", {req_ready, rsp_valid, rsp_id, rsp_data, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // round robin with everyone valid
    req_data  = {16'h8000, 16'h0001, 16'h0F00, 16'hFFFF};
    req_valid = 4'b1111;
    #1 check_val("rr_gnt", {28'd0, req_ready}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      wait_rsp("rr", n);
      if (i == 0) begin
        check_val("rr_lat", n, clz_lat + 2);
      end else begin
        check_val("rr_gap", n, clz_lat + 3);
      end
      check_val("rr_id", {30'd0, rsp_id}, exp_id[i]);
      check_val("rr_data", {28'd0, rsp_data}, exp_d[i]);
      if (i == 4) begin
        req_valid = 4'b0000;
      end else begin
        req_valid = 4'b1111;
      end
    end

    // single request
    @(negedge clk);
    req_data[15:0] = 16'h00FF;
    req_valid      = 4'b0001;
    #1 check_val("one_gnt", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1 check_val("one_busy", {27'd0, req_ready, busy}, 32'h1);
    wait_rsp("one", n);
    check_val("one_lat", n + 1, clz_lat + 2);
    check_val("one_rsp", {26'd0, rsp_id, rsp_data}, {26'd0, 2'd0, 4'd8});

    // back-pressure
    @(negedge clk);
    rsp_ready        = 1'b0;
    req_data[47:32]  = 16'h0010;
    req_valid        = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp("bp", n);
    req_valid = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp_hold", {21'd0, rsp_valid, rsp_id, rsp_data, req_ready},
                {21'd0, 1'b1, 2'd2, 4'd11, 4'b0000});
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    check_val("bp_done", {30'd0, rsp_valid, busy}, 32'd0);

    // pointer wrap: 3, then 0 ahead of 2
    req_data[63:48] = 16'h0100;
    req_valid       = 4'b1000;
    #1 check_val("wrap_g3", {28'd0, req_ready}, 32'h8);
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp("wrap3", n);
    check_val("wrap3_rsp", {26'd0, rsp_id, rsp_data}, {26'd0, 2'd3, 4'd7});
    req_data[15:0]  = 16'h0002;
    req_data[47:32] = 16'h4000;
    req_valid       = 4'b0101;
    @(negedge clk);
    check_val("wrap_g0", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 4'b0100;
    wait_rsp("wrap0", n);
    check_val("wrap0_rsp", {26'd0, rsp_id, rsp_data}, {26'd0, 2'd0, 4'd14});
    @(negedge clk);
    check_val("wrap_g2", {28'd0, req_ready}, 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp("wrap2", n);
    check_val("wrap2_rsp", {26'd0, rsp_id, rsp_data}, {26'd0, 2'd2, 4'd1});

    // reset during WAIT
    @(negedge clk);
    req_data[31:16] = 16'h0F0F;
    req_valid       = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    #1 check_val("rst_async", {req_ready, rsp_valid, rsp_id, rsp_data, busy}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("rst_hold", {30'd0, rsp_valid, busy}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_quiet", {30'd0, rsp_valid, busy}, 32'd0);
    end
    req_data[15:0] = 16'h0003;
    req_valid      = 4'b1001;
    #1 check_val("rst_ptr", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp("rst_req", n);
    check_val("rst_lat", n + 1, clz_lat + 2);
    check_val("rst_rsp", {26'd0, rsp_id, rsp_data}, {26'd0, 2'd0, 4'd14});

    // operand changes while busy are ignored
    @(negedge clk);
    req_data[31:16] = 16'h2000;
    req_valid       = 4'b0010;
    @(negedge clk);
    req_valid       = 4'b0000;
    req_data[31:16] = 16'h0001;
    @(negedge clk);
    req_data[31:16] = 16'hFFFF;
    wait_rsp("hold", n);
    check_val("hold_rsp", {26'd0, rsp_id, rsp_data}, {26'd0, 2'd1, 4'd2});

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
